// File: rtl/pipe_reg_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_reg_pkg
// Brief  : Shared defaults and occupancy-width helper for pipe_reg_chain.
// Rev    : 1.0
// ============================================================================
package pipe_reg_pkg;

  localparam int c_default_width = 32;
  localparam int c_default_depth = 2;

  // DEPTH+1 distinct counts (0..DEPTH) need this many bits.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_reg_chain_if
// Brief  : Valid/ready payload bus between a producer/consumer and the chain.
// Rev    : 1.0
// ============================================================================
interface pipe_reg_chain_if
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = c_default_width
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, q
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain_stage.sv
`default_nettype none
// ============================================================================
// Module : pipe_reg_stage
// Brief  : One pipeline slot: valid bit plus payload with load/hold/clear.
// Rev    : 1.0
// ============================================================================
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Clear only drops the valid bit; stale data stays visible on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module : pipe_reg_chain
// Brief  : DEPTH-stage valid/ready register chain with bubble collapsing.
//          Define PIPE_REG_CHAIN_OCC_EN to add the occupancy output.
// Rev    : 1.0
// ============================================================================
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int DEPTH = c_default_depth
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic flush,
  pipe_reg_chain_if.slave bus
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_rdy;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic             w_adv;
  logic             w_in_ready;

  assign w_adv      = enable & ~flush;
  assign w_in_ready = w_rdy[0] & w_adv & ~reset;

  assign bus.in_ready  = w_in_ready;
  // Reset also masks the output so no transfer is seen while in-flight data is discarded.
  assign bus.out_valid = w_valid[DEPTH-1] & w_adv & ~reset;
  assign bus.q         = w_data[DEPTH-1];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_vin;
      logic [WIDTH-1:0] w_din;

      // A stage can take data unless it and every stage downstream are full and stalled.
      assign w_rdy[i] = ~(&w_valid[DEPTH-1:i]) | bus.out_ready;

      if (i == 0) begin : g_head
        assign w_vin = bus.in_valid & w_in_ready;
        assign w_din = bus.d;
      end else begin : g_body
        assign w_vin = w_valid[i-1];
        assign w_din = w_data[i-1];
      end

      pipe_reg_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst     (reset),
        .i_clear (flush),
        .i_load  (w_adv & w_rdy[i]),
        .i_valid (w_vin),
        .i_data  (w_din),
        .o_valid (w_valid[i]),
        .o_data  (w_data[i])
      );
    end
  endgenerate

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int c_occ_w = occ_width(DEPTH);
  logic [c_occ_w-1:0] w_occ;

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + c_occ_w'(w_valid[i]);
    end
  end

  assign occupancy = w_occ;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_reg_chain
// Brief  : Directed scoreboard bench for pipe_reg_chain (WIDTH=8, DEPTH=3).
// Rev    : 1.0
// ============================================================================
module tb_pipe_reg_chain;
  import pipe_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic flush;

  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [occ_width(DEPTH)-1:0] occupancy;
`endif

  pipe_reg_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .flush  (flush),
    .bus    (bus)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_out  = 0;

  logic [WIDTH-1:0] sb [$];
  logic obs_acc;
  logic obs_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, update the model at the rising edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                      input logic en = 1'b1, input logic fl = 1'b0, input logic rs = 1'b0);
    logic [WIDTH-1:0] exp_q;
    bus.in_valid  = iv;
    bus.d         = id;
    bus.out_ready = ordy;
    enable        = en;
    flush         = fl;
    reset         = rs;
    @(negedge clk);
    obs_ov = bus.out_valid;
    chk("in_ready", bus.in_ready, en & ~fl & ~rs & ((sb.size() < DEPTH) | ordy));
    if (!en || fl || rs || sb.size() == 0)
      chk("out_valid_idle", bus.out_valid, 1'b0);
    else if (sb.size() == DEPTH)
      chk("out_valid_full", bus.out_valid, 1'b1);
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk("occupancy", occupancy, sb.size());
`endif
    obs_acc = iv & bus.in_ready;
    if (bus.out_valid & ordy) begin
      n_out++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL q_spurious: observed %0h expected no output", bus.q);
      end else begin
        exp_q = sb.pop_front();
        chk("q_order", bus.q, exp_q);
      end
    end
    if (obs_acc) begin
      sb.push_back(id);
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (rs || fl) sb.delete();
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() > 0; c++) step(1'b0, '0, 1'b1);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [7:0] nv;
    int a0;
    int o0;

    // Reset, then the first idle cycle must show ready, invalid, zero data.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rst_q", bus.q, 8'h00);

    // Latency into an empty chain.
    step(1'b1, 8'h11, 1'b1);
    chk("accept_11", obs_acc, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, '0, 1'b1);
      chk($sformatf("latency_%0d", k), obs_ov, (k == 3));
    end

    // Back-pressure fill then stream out at one per cycle.
    nv = 8'h01;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, nv, 1'b0);
      if (obs_acc) nv++;
    end
    chk("full_accepts", nv, 8'h04);
    o0 = n_out;
    for (int c = 0; c < 6; c++) begin
      step(nv <= 8'h06, nv, 1'b1);
      if (obs_acc) nv++;
    end
    chk("stream_outs", n_out - o0, 6);
    chk("stream_sent", nv, 8'h07);
    chk("stream_empty", sb.size(), 0);

    // Full chain with simultaneous input and output transfers.
    for (int c = 0; c < 3; c++) step(1'b1, 8'h40 + 8'(c), 1'b0);
    a0 = n_acc;
    o0 = n_out;
    for (int c = 0; c < 10; c++) step(1'b1, 8'h50 + 8'(c), 1'b1);
    chk("full_accepts10", n_acc - a0, 10);
    chk("full_outputs10", n_out - o0, 10);
    chk("full_level", sb.size(), DEPTH);
    drain();

    // Flush drops held payloads and refuses the offered one.
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    chk("flush_refused", obs_acc, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b1);
      chk("flush_ov", obs_ov, 1'b0);
    end

    // Stall mid-stream, then resume without loss.
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h31, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'h32, 1'b1, 1'b0);
      chk("stall_acc", obs_acc, 1'b0);
    end
    nv = 8'h32;
    for (int c = 0; c < 4; c++) begin
      step(nv <= 8'h33, nv, 1'b1);
      if (obs_acc) nv++;
    end
    chk("resume_sent", nv, 8'h34);
    drain();

    // Reset with two payloads in flight.
    step(1'b1, 8'h61, 1'b1);
    step(1'b1, 8'h62, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rst_mid_ov", obs_ov, 1'b0);
    chk("rst_mid_q", bus.q, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, '0, 1'b1);
      chk("rst_mid_quiet", obs_ov, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages (>=1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port enable  input  1  global advance enable; low freezes all stages.
REQ-006 The block SHALL have port flush  input  1  synchronous invalidate of all stages.
REQ-007 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 The block SHALL have port in_ready  output  1  block accepts payload this cycle.
REQ-009 The block SHALL have port d  input  WIDTH  upstream payload.
REQ-010 The block SHALL have port out_valid  output  1  stage DEPTH-1 holds valid payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts payload.
REQ-012 The block SHALL have port q  output  WIDTH  payload of stage DEPTH-1.
REQ-013 The block SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages, present only per REQ-030.

Function
REQ-014 Each stage i SHALL hold a valid bit v[i] and a WIDTH-bit data register; stage 0 is fed by d, and stage DEPTH-1 drives q.
REQ-015 Stage readiness SHALL be computed combinationally: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready, rdy[i] = !v[i] | rdy[i+1], with bubbles collapsing in the same cycle.
REQ-016 in_ready SHALL equal rdy[0] & enable & !flush & !reset.
REQ-017 out_valid SHALL equal v[DEPTH-1] & enable & !flush; q SHALL always show stage DEPTH-1 data, irrespective of the valid bit.
REQ-018 A transfer SHALL occur at the input when in_valid & in_ready, and at the output when out_valid & out_ready.
REQ-019 When enable=1 and flush=0 and rdy[i]=1, stage i SHALL load the data and valid bit of stage i-1 (stage 0 loads d and in_valid & in_ready); when rdy[i]=0 it SHALL hold.
REQ-020 Minimum latency from input transfer to out_valid SHALL be DEPTH cycles into an empty chain; sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-021 When enable=0 and flush=0, all valid and data registers SHALL hold and no transfer SHALL occur on either side.
REQ-022 When flush=1, all v[i] SHALL clear at the next edge regardless of enable; input is refused and no output transfer occurs that cycle.
REQ-023 Full chain with out_ready=0 SHALL drive in_ready=0; simultaneous input and output transfer on a full chain SHALL be accepted without loss.
REQ-024 Priority SHALL be reset > flush > enable.
REQ-025 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush or reset.

Reset
REQ-026 On reset=1 at a rising edge, all v[i] SHALL clear and all data registers SHALL load zero.
REQ-027 After reset: out_valid=0, q=0, occupancy=0; in_ready=0 while reset is high, then 1 in the first cycle after reset when enable=1.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight payloads with no output transfer in that cycle.

Configuration
REQ-029 The feature SHALL be controlled by macro PIPE_REG_CHAIN_OCC_EN.
REQ-030 With PIPE_REG_CHAIN_OCC_EN defined, the occupancy port SHALL exist and equal the registered population count of v[]. Without it, the port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-031 A shared package pipe_reg_pkg SHALL hold the occupancy-width function and the default WIDTH/DEPTH constants.
REQ-032 A single sub-module pipe_reg_stage (one valid bit, WIDTH data, load/hold/clear) SHALL be instantiated DEPTH times via generate.

Verification
REQ-033 With WIDTH=8, DEPTH=3, reset then push 0x11 with out_ready=1 -> out_valid=1 and q=0x11 exactly 3 cycles after acceptance.
REQ-034 Push 0x01..0x06 back-to-back with out_ready=0 -> in_ready falls after 3 accepts and occupancy=3; raise out_ready -> 0x01..0x06 emerge in order, one per cycle.
REQ-035 Full chain with in_valid=1, out_ready=1 for 10 cycles -> 10 accepts, 10 outputs, occupancy stays 3.
REQ-036 Chain holding 0xA0, 0xA1 with flush=1 for one cycle -> next cycle out_valid=0 and occupancy=0; the input offered during flush is not accepted.
REQ-037 With enable=0 for 4 cycles mid-stream -> in_ready=0, out_valid=0, and stage contents unchanged; resuming with enable=1 restores order with no loss.
REQ-038 Assert reset with 2 payloads in flight -> next cycle out_valid=0, q=0, occupancy=0.
